// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Iterative shift-add multiply and restoring divide with HI/LO results.
module muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic           md_op;
  logic           op_div;
  logic           op_sgn;
  logic           accept;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_sh;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  // 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
  assign md_op  = (funct[5:2] == 4'b0110);
  assign op_div = funct[1];
  assign op_sgn = ~funct[0];
  assign accept = start & md_op & ~flush;

  assign mag_a = (op_sgn & operand_1[W-1]) ? -operand_1 : operand_1;
  assign mag_b = (op_sgn & operand_2[W-1]) ? -operand_2 : operand_2;

  // Multiplier bits live in acc low half, shifted out LSB first
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]}
                  + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Remainder in acc high half, dividend/quotient in low half
  assign div_sh   = acc_q[2*W-1:W-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_next = div_diff[W]
                  ? {acc_q[2*W-2:0], 1'b0}
                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

  assign step = is_div_q ? div_next : mul_next;
  assign prod = neg_quo_q ? -step : step;
  assign quo  = neg_quo_q ? -step[W-1:0] : step[W-1:0];
  assign rem  = neg_rem_q ? -step[2*W-1:W] : step[2*W-1:W];

  assign stall_req = ((state_q == S_IDLE) & accept)
                   | (state_q == S_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_d     = {{W{1'b0}}, mag_a};
            opb_d     = mag_b;
            is_div_d  = op_div;
            neg_quo_d = op_sgn & (operand_1[W-1] ^ operand_2[W-1]);
            neg_rem_d = op_sgn & operand_1[W-1];
            cnt_d     = '0;
            if (op_div && (operand_2 == '0)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hi_d    = operand_1;
              lo_d    = '1;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
            if (is_div_q) begin
              hi_d = rem;
              lo_d = quo;
            end else begin
              hi_d = prod[2*W-1:W];
              lo_d = prod[W-1:0];
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, corner
// sequences and random ops against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [5:0]   funct;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         stall_req;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .operand_1(op1), .operand_2(op2), .flush(flush),
    .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}
  function automatic logic [63:0] model(input logic [5:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      6'h18: p = 64'(sa * sb);
      6'h19: p = {32'b0, a} * {32'b0, b};
      6'h1A, 6'h1B: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (f == 6'h1B) p = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Issue one op, follow it to done; poke keeps start high while busy
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit poke,
                        output int lat, output logic [31:0] rhi,
                        output logic [31:0] rlo);
    bit stall_bad;
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; funct = f; op1 = a; op2 = b;
    @(negedge clk);
    stall_bad = (stall_req !== 1'b1) || (done !== 1'b0);
    @(posedge clk); #1;
    if (poke) begin
      funct = 6'h18; op1 = $urandom; op2 = $urandom;
    end else begin
      start = 1'b0;
    end
    cyc = 1;
    lat = -1;
    rhi = 'x;
    rlo = 'x;
    while (cyc <= 100) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc;
        rhi = hi;
        rlo = lo;
        break;
      end
      if (stall_req !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (stall_req !== 1'b0) stall_bad = 1'b1;
    chk("stall_pattern", 64'(stall_bad), 64'd0);
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat;
    logic [31:0] rhi, rlo;
    logic [63:0] exp;
    logic [5:0] f;
    logic [31:0] a, b;
    bit seen;

    tbl[0] = '{6'h18, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    tbl[1] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    tbl[2] = '{6'h19, 32'h0,        32'h5,        32'h0,        32'h0,        33};
    tbl[3] = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    tbl[4] = '{6'h1A, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[5] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33};
    tbl[6] = '{6'h1B, 32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 1};
    tbl[7] = '{6'h1A, 32'h80000000, 32'h0,        32'h80000000, 32'hFFFFFFFF, 1};
    tbl[8] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        33};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {29'b0, done, stall_req, 1'b0, hi ^ lo}, 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, back-to-back; odd entries poke start while busy
    foreach (tbl[i]) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, (i % 2) == 1, lat, rhi, rlo);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_hi", i), 64'(rhi), 64'(tbl[i].hi));
      chk($sformatf("tbl%0d_lo", i), 64'(rlo), 64'(tbl[i].lo));
    end

    // done is a single pulse; hi/lo hold afterwards
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("hold_hilo", {hi, lo}, {32'h40000000, 32'h0});

    // Non-md funct is ignored
    @(posedge clk); #1;
    start = 1'b1; funct = 6'h21; op1 = 32'd9; op2 = 32'd3;
    @(negedge clk);
    chk("addu_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("addu_idle", {62'b0, stall_req, done}, 64'd0);
    run_op(6'h1B, 32'd100, 32'd7, 1'b0, lat, rhi, rlo);
    chk("after_addu_lat", 64'(lat), 64'd33);
    chk("after_addu_res", {rhi, rlo}, {32'd2, 32'd14});

    // Flush mid-divide at T+10
    @(posedge clk); #1;
    start = 1'b1; funct = 6'h1A; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'b0, stall_req, done}, 64'd0);
    chk("flush_hold", {hi, lo}, {32'd2, 32'd14});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);

    // Reset (with flush) mid-divide at T+10
    @(posedge clk); #1;
    start = 1'b1; funct = 6'h1A; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {62'b0, stall_req, done}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: a = 32'($urandom_range(0, 20));
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      exp = model(f, a, b);
      run_op(f, a, b, n[0], lat, rhi, rlo);
      chk($sformatf("rnd%0d_f%0h_lat", n, f), 64'(lat),
          (f[1] && b == 0) ? 64'd1 : 64'd33);
      chk($sformatf("rnd%0d_f%0h_%0h_%0h", n, f, a, b),
          {rhi, rlo}, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU requests whose ALU function code comes from ID.
- Runs an iterative shift-add multiplier or a restoring divider for DATA_WIDTH iterations.
- Stalls the pipeline while busy, then presents HI/LO results for one cycle for the HI/LO register write.

Parameters:
DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.
CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request valid from EX; sampled only in IDLE.
funct  input  6  function code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; any other value is not an md-op.
operand_1  input  DATA_WIDTH  rs value (multiplicand / dividend).
operand_2  input  DATA_WIDTH  rt value (multiplier / divisor).
flush  input  1  exception/flush from pipeline control; aborts the operation.
stall_req  output  1  pipeline stall request (combinational).
done  output  1  results valid, one-cycle pulse.
hi  output  DATA_WIDTH  high product word or remainder.
lo  output  DATA_WIDTH  low product word or quotient.

Behaviour:
Reset:
- rst=1 forces state to IDLE and clears the counter, done, hi, lo and internal registers to 0, regardless of state (including mid-operation).

States: IDLE, BUSY, DONE.

IDLE:
- When start=1, the funct is an md-op and flush=0: latch the operands and op.
- Signed ops (MULT, DIV): latch operand magnitudes; record sign_q = sign1^sign2 and sign_r = sign1.
- Then go to BUSY with counter=0.
- DIV/DIVU with operand_2=0: go straight to DONE (no iterations).
- start=1 with a non-md funct is ignored.

BUSY:
- One iteration per cycle, counter increments each cycle.
- Multiply: 2*DATA_WIDTH-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
- Divide: restoring shift-subtract; one quotient bit per cycle.
- After DATA_WIDTH cycles (counter = DATA_WIDTH-1 on the final one), go to DONE.

DONE:
- done=1 for exactly one cycle with hi/lo valid; next state is IDLE.
- hi/lo hold their value after DONE until the next DONE or reset.

Latency:
- start accepted in cycle T gives done=1 in cycle T+DATA_WIDTH+1 (T+33 by default).
- Divide-by-zero: done in T+1.

stall_req:
- Equals (IDLE & start & md-op & ~flush) | BUSY.
- It is 0 in DONE so the instruction advances with the result.

Sign fix-up, applied on entry to DONE:
- MULT: negate the 64-bit product if sign_q.
- DIV: negate the quotient if sign_q; negate the remainder if sign_r.
- Unsigned ops: no fix-up.

Boundary cases:
- Divide by zero: hi = operand_1, lo = all ones.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps naturally, no trap).
- flush=1 in any state: next state IDLE, done stays 0, hi/lo unchanged. flush has priority over start.
- start during BUSY or DONE: ignored; the requester is stalled by stall_req.
- Simultaneous rst and flush: rst wins.

Test Plan:
- MULT 7 × 0xFFFFFFFD (-3), start at T: stall_req high T..T+32; at T+33 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 at T+33. MULTU 0 × 5: hi=lo=0.
- DIVU 100 / 7: lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 0x1234 / 0: done at T+1, hi=0x1234, lo=0xFFFFFFFF, stall_req high only in cycle T.
- Start DIV, assert flush at T+10: IDLE at T+11, no done pulse, hi/lo keep prior values. Repeat with rst at T+10: all outputs 0.
- Second start asserted during BUSY is ignored. start with funct=0x21 (ADDU): stall_req=0, state stays IDLE. Back-to-back ops: the second is accepted in the cycle after DONE.
